// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide, one bit per cycle.
// Divider compiled in only when MULDIV_DIV_EN is defined.
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 3'd2,
`endif
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           f3_q, f3_d;
    logic [WIDTH-1:0]     op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 illegal_q, illegal_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & a[WIDTH-1];
        b_neg    = b_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        // Unsigned ops have both sign flags clear, so only REM needs its own rule.
        neg_in   = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    end

    // Multiply: high half accumulates the multiplicand, low half shifts out multiplier bits.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_q : acc_q;
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff, div_sel, div_res;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    // Restoring divide: high half is the partial remainder, low half the dividend/quotient.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, op_q});
        div_diff  = div_shift[WIDTH-1:0] - op_q;
        div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        div_sel   = f3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        div_res   = neg_q ? -div_sel : div_sel;
    end
`endif

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        op_d      = op_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d      = funct3;
                    neg_d     = neg_in;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    illegal_d = 1'b0;
                    if (!funct3[2]) begin
                        op_d    = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        state_d = S_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (b == '0) begin
                            result_d = funct3[1] ? a : {WIDTH{1'b1}};
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                        end else if (!funct3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                     (b == {WIDTH{1'b1}})) begin
                            result_d = funct3[1] ? '0 : a;
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                        end else begin
                            op_d    = b_mag;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            state_d = S_DIV;
                        end
`else
                        result_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                        done_d    = 1'b1;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                acc_d = div_next;
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            S_FIX: begin
                if (f3_q[2]) begin
`ifdef MULDIV_DIV_EN
                    result_d = div_res;
`else
                    result_d = '0;
`endif
                end else begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything: no done pulse and the previous result stays visible.
        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed bench for muldiv_unit with a behavioural model.
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a, b;
    logic             flush;
    logic             busy, done, illegal;
    logic [WIDTH-1:0] result;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          tick   = 0;
    bit          mon_en = 1'b0;
    bit          exp_act = 1'b0;
    bit          exp_done, exp_use_lit;
    int          exp_st, exp_end;
    logic [31:0] exp_res, exp_lit, last_res;
    logic        exp_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic ill, output int lat);
        longint          sx, sy, p;
        longint unsigned ux, uy, pu;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ill = 1'b0;
        lat = LAT;
        r   = '0;
        case (f)
            3'b000: begin pu = ux * uy;           r = pu[31:0];  end
            3'b001: begin p  = sx * sy;           r = p[63:32];  end
            3'b010: begin p  = sx * longint'(uy); r = p[63:32];  end
            3'b011: begin pu = ux * uy;           r = pu[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 32'd0) begin
                    lat = 1;
                    r   = f[1] ? x : 32'hFFFF_FFFF;
                end else if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r   = f[1] ? 32'd0 : x;
                end else begin
                    case (f[1:0])
                        2'b00:   begin p = sx / sy; r = p[31:0]; end
                        2'b01:   r = x / y;
                        2'b10:   begin p = sx % sy; r = p[31:0]; end
                        default: r = x % y;
                    endcase
                end
`else
                r   = '0;
                ill = 1'b1;
                lat = 1;
`endif
            end
        endcase
    endtask

    // Compare process: every cycle after reset, outputs are checked against the model.
    initial begin
        int cyc;
        forever begin
            @(posedge clk);
            #1;
            tick++;
            if (mon_en) begin
                if (exp_act && (tick - exp_st) > exp_end) exp_act = 1'b0;
                if (exp_act) begin
                    cyc = tick - exp_st;
                    check("busy", {31'd0, busy}, 32'd1);
                    check("done", {31'd0, done}, {31'd0, (exp_done && cyc == exp_end)});
                    if (exp_done && cyc == exp_end) begin
                        check("result", result, exp_res);
                        check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
                        if (exp_use_lit) check("result_literal", result, exp_lit);
                        last_res = exp_res;
                        exp_act  = 1'b0;
                    end
                end else begin
                    check("idle_busy", {31'd0, busy}, 32'd0);
                    check("idle_done", {31'd0, done}, 32'd0);
                    check("held_result", result, last_res);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_act; i++) @(negedge clk);
        if (exp_act) begin
            checks++;
            errors++;
            $display("FAIL timeout: got busy op expected done within 200 cycles");
            exp_act = 1'b0;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input bit use_lit, input logic [31:0] lit);
        logic [31:0] m_res;
        logic        m_ill;
        int          m_lat;
        wait_idle();
        @(posedge clk);
        @(negedge clk);
        model(f, x, y, m_res, m_ill, m_lat);
        exp_res     = m_res;
        exp_ill     = m_ill;
        exp_end     = m_lat;
        exp_done    = 1'b1;
        exp_lit     = lit;
        exp_use_lit = use_lit;
        exp_st      = tick;
        exp_act     = 1'b1;
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
        check({tag, "_done"},    {31'd0, done},    32'd0);
        check({tag, "_result"},  result,           32'd0);
        check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = '0;
        a       = '0;
        b       = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Multiply family
        do_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
        do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
        do_op(3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
        do_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0);
        do_op(3'b001, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 32'h0);

        // Divide family
`ifdef MULDIV_DIV_EN
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        do_op(3'b101, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF);
        do_op(3'b111, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_1234);
        do_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD);
        do_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1, 32'h0000_0002);
        do_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 32'h5555_5555);
        do_op(3'b100, 32'h0000_0007, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF);
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
`else
        do_op(3'b100, 32'h0000_0008, 32'h0000_0002, 1'b1, 32'h0000_0000);
        do_op(3'b111, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_0000);
`endif
        do_op(3'b011, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 32'h0000_000D);

        // Start while busy is ignored (would be a one-cycle special case if accepted)
        do_op(3'b001, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b101;
        a      = 32'h0000_0055;
        b      = 32'h0000_0000;
        @(negedge clk);
        start  = 1'b0;

        // Flush in cycle 10, together with a competing start
        do_op(3'b000, 32'h0001_0003, 32'h0000_0007, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        flush    = 1'b1;
        start    = 1'b1;
        funct3   = 3'b000;
        exp_end  = 10;
        exp_done = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        do_op(3'b000, 32'h0000_0101, 32'h0000_0003, 1'b1, 32'h0000_0303);

        // Flush beats start when both arrive in IDLE
        wait_idle();
        @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b000;
        a      = 32'h5;
        b      = 32'h7;
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an iterative operation
`ifdef MULDIV_DIV_EN
        do_op(3'b100, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0);
`else
        do_op(3'b011, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0);
`endif
        repeat (5) @(negedge clk);
        mon_en  = 1'b0;
        exp_act = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        check_zero_outputs("midreset");
        @(negedge clk);
        reset_n  = 1'b1;
        last_res = '0;
        mon_en   = 1'b1;
        do_op(3'b001, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000);

        wait_idle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
